// File: rtl/wb_la_port_arbiter.sv
// Round-robin arbiter sharing one target port between the Wishbone slave and an LA command channel.
// WB stb->t_req 1 cycle, t_ack->ack 1 cycle (LA +2 sync); one transfer in flight; ARB_WATCHDOG_EN adds a timeout IRQ.
module wb_la_port_arbiter #(
  parameter logic [31:0] BASE_ADDR      = 32'h3000_0000,
  parameter int          ADDR_W         = 8,
  parameter int          TIMEOUT_CYCLES = 255
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              wbs_cyc_i,
  input  logic              wbs_stb_i,
  input  logic              wbs_we_i,
  input  logic [3:0]        wbs_sel_i,
  input  logic [31:0]       wbs_adr_i,
  input  logic [31:0]       wbs_dat_i,
  output logic              wbs_ack_o,
  output logic [31:0]       wbs_dat_o,
  input  logic              la_req_i,
  input  logic              la_we_i,
  input  logic [ADDR_W-1:0] la_adr_i,
  input  logic [31:0]       la_dat_i,
  output logic              la_ack_o,
  output logic [31:0]       la_dat_o,
  output logic              t_req_o,
  output logic              t_we_o,
  output logic [3:0]        t_sel_o,
  output logic [ADDR_W-1:0] t_adr_o,
  output logic [31:0]       t_dat_o,
  input  logic              t_ack_i,
  input  logic [31:0]       t_dat_i,
  output logic              irq_o
);

  typedef enum logic [2:0] {IDLE, BUSY_WB, BUSY_LA, WB_ACK, LA_WAIT} state_t;
  localparam logic GNT_WB = 1'b0;
  localparam logic GNT_LA = 1'b1;

  state_t            state_q, state_d;
  logic              la_meta_q, la_meta_d;
  logic              la_sync_q, la_sync_d;
  logic              last_grant_q, last_grant_d;
  logic              abort_q, abort_d;
  logic              t_req_q, t_req_d;
  logic              t_we_q, t_we_d;
  logic [3:0]        t_sel_q, t_sel_d;
  logic [ADDR_W-1:0] t_adr_q, t_adr_d;
  logic [31:0]       t_dat_q, t_dat_d;
  logic              wbs_ack_q, wbs_ack_d;
  logic [31:0]       wbs_dat_q, wbs_dat_d;
  logic              la_ack_q, la_ack_d;
  logic [31:0]       la_dat_q, la_dat_d;

  logic              la_req_s, wb_pend, la_pend, busy, tmo;
  logic              grant_wb, grant_la;
  logic [31:0]       rdata;
  logic              unused_ok;

  assign unused_ok = &{1'b0, wbs_adr_i[1:0], (TIMEOUT_CYCLES > 0)};

  assign la_req_s = la_sync_q;
  assign wb_pend  = wbs_cyc_i & wbs_stb_i &
                    (wbs_adr_i[31:ADDR_W+2] == BASE_ADDR[31:ADDR_W+2]);
  assign la_pend  = la_req_s & ~la_ack_q;
  assign busy     = (state_q == BUSY_WB) || (state_q == BUSY_LA);

`ifdef ARB_WATCHDOG_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] wdog_q, wdog_d;
  logic             irq_q, irq_d;

  // Held at zero outside BUSY, so every BUSY entry starts counting from 0.
  always_comb begin
    wdog_d = '0;
    if (busy) wdog_d = wdog_q + CNT_W'(1);
    irq_d = tmo;
  end

  assign tmo   = busy && (wdog_q == CNT_W'(TIMEOUT_CYCLES - 1)) && !t_ack_i;
  assign irq_o = irq_q;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      wdog_q <= '0;
      irq_q  <= 1'b0;
    end else begin
      wdog_q <= wdog_d;
      irq_q  <= irq_d;
    end
  end
`else
  assign tmo   = 1'b0;
  assign irq_o = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    la_meta_d    = la_req_i;
    la_sync_d    = la_meta_q;
    last_grant_d = last_grant_q;
    abort_d      = abort_q;
    t_req_d      = t_req_q;
    t_we_d       = t_we_q;
    t_sel_d      = t_sel_q;
    t_adr_d      = t_adr_q;
    t_dat_d      = t_dat_q;
    wbs_ack_d    = wbs_ack_q;
    wbs_dat_d    = wbs_dat_q;
    la_ack_d     = la_ack_q;
    la_dat_d     = la_dat_q;
    grant_wb     = 1'b0;
    grant_la     = 1'b0;
    rdata        = t_we_q ? 32'h0 : (tmo ? 32'hDEAD_BEEF : t_dat_i);

    case (state_q)
      IDLE: begin
        // last_grant only moves on a tie, so single requests never skew fairness.
        if (wb_pend && la_pend) begin
          grant_wb     = (last_grant_q == GNT_LA);
          grant_la     = ~grant_wb;
          last_grant_d = grant_wb ? GNT_WB : GNT_LA;
        end else begin
          grant_wb = wb_pend;
          grant_la = la_pend;
        end
        if (grant_wb) begin
          state_d = BUSY_WB;
          t_req_d = 1'b1;
          t_we_d  = wbs_we_i;
          t_sel_d = wbs_sel_i;
          t_adr_d = wbs_adr_i[ADDR_W+1:2];
          t_dat_d = wbs_dat_i;
          abort_d = 1'b0;
        end else if (grant_la) begin
          state_d = BUSY_LA;
          t_req_d = 1'b1;
          t_we_d  = la_we_i;
          t_sel_d = 4'hF;
          t_adr_d = la_adr_i;
          t_dat_d = la_dat_i;
        end
      end
      BUSY_WB: begin
        if (!wbs_cyc_i) abort_d = 1'b1;
        if (t_ack_i || tmo) begin
          t_req_d = 1'b0;
          state_d = WB_ACK;
          if (!abort_q && wbs_cyc_i) begin
            wbs_ack_d = 1'b1;
            wbs_dat_d = rdata;
          end
        end
      end
      BUSY_LA: begin
        if (t_ack_i || tmo) begin
          t_req_d  = 1'b0;
          state_d  = LA_WAIT;
          la_ack_d = 1'b1;
          la_dat_d = rdata;
        end
      end
      WB_ACK: begin
        wbs_ack_d = 1'b0;
        wbs_dat_d = 32'h0;
        state_d   = IDLE;
      end
      LA_WAIT: begin
        if (!la_req_s) begin
          la_ack_d = 1'b0;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q      <= IDLE;
      la_meta_q    <= 1'b0;
      la_sync_q    <= 1'b0;
      last_grant_q <= GNT_LA;
      abort_q      <= 1'b0;
      t_req_q      <= 1'b0;
      t_we_q       <= 1'b0;
      t_sel_q      <= 4'h0;
      t_adr_q      <= '0;
      t_dat_q      <= 32'h0;
      wbs_ack_q    <= 1'b0;
      wbs_dat_q    <= 32'h0;
      la_ack_q     <= 1'b0;
      la_dat_q     <= 32'h0;
    end else begin
      state_q      <= state_d;
      la_meta_q    <= la_meta_d;
      la_sync_q    <= la_sync_d;
      last_grant_q <= last_grant_d;
      abort_q      <= abort_d;
      t_req_q      <= t_req_d;
      t_we_q       <= t_we_d;
      t_sel_q      <= t_sel_d;
      t_adr_q      <= t_adr_d;
      t_dat_q      <= t_dat_d;
      wbs_ack_q    <= wbs_ack_d;
      wbs_dat_q    <= wbs_dat_d;
      la_ack_q     <= la_ack_d;
      la_dat_q     <= la_dat_d;
    end
  end

  assign wbs_ack_o = wbs_ack_q;
  assign wbs_dat_o = wbs_dat_q;
  assign la_ack_o  = la_ack_q;
  assign la_dat_o  = la_dat_q;
  assign t_req_o   = t_req_q;
  assign t_we_o    = t_we_q;
  assign t_sel_o   = t_sel_q;
  assign t_adr_o   = t_adr_q;
  assign t_dat_o   = t_dat_q;

endmodule

// File: tb/tb_wb_la_port_arbiter.sv
// Scoreboard bench for wb_la_port_arbiter: expected target requests and read data are queued at stimulus time.
module tb_wb_la_port_arbiter;

  typedef struct packed {
    logic        we;
    logic [3:0]  sel;
    logic [7:0]  adr;
    logic [31:0] dat;
  } treq_t;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_i;
  logic        wbs_cyc_i, wbs_stb_i, wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i, wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;
  logic        la_req_i, la_we_i;
  logic [7:0]  la_adr_i;
  logic [31:0] la_dat_i;
  logic        la_ack_o;
  logic [31:0] la_dat_o;
  logic        t_req_o, t_we_o;
  logic [3:0]  t_sel_o;
  logic [7:0]  t_adr_o;
  logic [31:0] t_dat_o;
  logic        t_ack_i;
  logic [31:0] t_dat_i;
  logic        irq_o;

  treq_t       exp_t[$];
  logic [31:0] exp_rd[$];
  logic        mdl_last_la;
  int          n_checks = 0;
  int          n_pass   = 0;

  always #5 wb_clk_i = ~wb_clk_i;

  wb_la_port_arbiter #(
    .BASE_ADDR(32'h3000_0000), .ADDR_W(8), .TIMEOUT_CYCLES(16)
  ) dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
    .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i), .wbs_we_i(wbs_we_i),
    .wbs_sel_i(wbs_sel_i), .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i),
    .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
    .la_req_i(la_req_i), .la_we_i(la_we_i), .la_adr_i(la_adr_i), .la_dat_i(la_dat_i),
    .la_ack_o(la_ack_o), .la_dat_o(la_dat_o),
    .t_req_o(t_req_o), .t_we_o(t_we_o), .t_sel_o(t_sel_o), .t_adr_o(t_adr_o),
    .t_dat_o(t_dat_o), .t_ack_i(t_ack_i), .t_dat_i(t_dat_i), .irq_o(irq_o)
  );

  task automatic tick();
    @(posedge wb_clk_i);
    #1;
  endtask

  task automatic test_reset();
    logic [111:0] obs;
    wb_rst_i = 1'b1;
    repeat (3) @(posedge wb_clk_i);
    #1;
    obs = {t_req_o, t_we_o, t_sel_o, t_adr_o, t_dat_o, wbs_ack_o, wbs_dat_o, la_ack_o, la_dat_o, irq_o};
    n_checks++;
    if (obs !== '0) $display("FAIL reset_outputs: got %h expected 0", obs);
    else n_pass++;
    wb_rst_i = 1'b0;
    mdl_last_la = 1'b1;
    repeat (3) tick();
    n_checks++;
    if ({t_req_o, wbs_ack_o, la_ack_o} !== 3'b000)
      $display("FAIL reset_idle: got %b expected 000", {t_req_o, wbs_ack_o, la_ack_o});
    else n_pass++;
  endtask

  task automatic wb_xfer(input logic [31:0] adr, input logic we, input logic [3:0] sel,
                         input logic [31:0] wdat, input int lat, input logic [31:0] rdat,
                         input string name);
    treq_t e, obs;
    logic [31:0] er;
    wbs_adr_i = adr; wbs_we_i = we; wbs_sel_i = sel; wbs_dat_i = wdat;
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1;
    e = '{we, sel, adr[9:2], wdat};
    exp_t.push_back(e);
    exp_rd.push_back(we ? 32'h0 : rdat);
    tick();
    n_checks++;
    if (t_req_o !== 1'b1) $display("FAIL %s_req_latency: t_req_o %b expected 1", name, t_req_o);
    else n_pass++;
    obs = {t_we_o, t_sel_o, t_adr_o, t_dat_o};
    e = exp_t.pop_front();
    n_checks++;
    if (obs !== e) $display("FAIL %s_fields: got %h expected %h", name, obs, e);
    else n_pass++;
    repeat (lat) tick();
    n_checks++;
    if (t_req_o !== 1'b1) $display("FAIL %s_req_held: t_req_o %b expected 1", name, t_req_o);
    else n_pass++;
    t_ack_i = 1'b1; t_dat_i = rdat;
    tick();
    t_ack_i = 1'b0; t_dat_i = 32'h0;
    er = exp_rd.pop_front();
    n_checks++;
    if ({wbs_ack_o, wbs_dat_o, t_req_o} !== {1'b1, er, 1'b0})
      $display("FAIL %s_ack: ack %b dat %h req %b expected ack 1 dat %h req 0",
               name, wbs_ack_o, wbs_dat_o, t_req_o, er);
    else n_pass++;
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
    tick();
    n_checks++;
    if ({wbs_ack_o, wbs_dat_o} !== 33'h0)
      $display("FAIL %s_ack_end: ack %b dat %h expected 0/0", name, wbs_ack_o, wbs_dat_o);
    else n_pass++;
  endtask

  task automatic la_xfer(input logic [7:0] adr, input logic we, input logic [31:0] wdat,
                         input int lat, input logic [31:0] rdat, input string name);
    treq_t e, obs;
    logic [31:0] er;
    int n;
    logic seen;
    la_adr_i = adr; la_we_i = we; la_dat_i = wdat; la_req_i = 1'b1;
    e = '{we, 4'hF, adr, wdat};
    exp_t.push_back(e);
    exp_rd.push_back(we ? 32'h0 : rdat);
    n = 0;
    while (!t_req_o && n < 10) begin tick(); n++; end
    n_checks++;
    if (n != 3) $display("FAIL %s_req_latency: %0d cycles expected 3", name, n);
    else n_pass++;
    obs = {t_we_o, t_sel_o, t_adr_o, t_dat_o};
    e = exp_t.pop_front();
    n_checks++;
    if (obs !== e) $display("FAIL %s_fields: got %h expected %h", name, obs, e);
    else n_pass++;
    repeat (lat) tick();
    t_ack_i = 1'b1; t_dat_i = rdat;
    tick();
    t_ack_i = 1'b0; t_dat_i = 32'h0;
    er = exp_rd.pop_front();
    n_checks++;
    if ({la_ack_o, la_dat_o, t_req_o} !== {1'b1, er, 1'b0})
      $display("FAIL %s_ack: ack %b dat %h req %b expected ack 1 dat %h req 0",
               name, la_ack_o, la_dat_o, t_req_o, er);
    else n_pass++;
    repeat (4) tick();
    n_checks++;
    if ({la_ack_o, t_req_o} !== 2'b10)
      $display("FAIL %s_ack_held: ack %b req %b expected 1 0", name, la_ack_o, t_req_o);
    else n_pass++;
    la_req_i = 1'b0;
    n = 0;
    while (la_ack_o && n < 10) begin tick(); n++; end
    n_checks++;
    if (n != 3) $display("FAIL %s_ack_drop: %0d cycles expected 3", name, n);
    else n_pass++;
    seen = 1'b0;
    repeat (6) begin tick(); if (t_req_o) seen = 1'b1; end
    n_checks++;
    if ({seen, la_dat_o} !== {1'b0, er})
      $display("FAIL %s_after: reissue %b dat %h expected 0 %h", name, seen, la_dat_o, er);
    else n_pass++;
  endtask

  task automatic test_wb_read();
    wb_xfer(32'h3000_0010, 1'b0, 4'h6, 32'h0000_0000, 3, 32'h1234_5678, "wb_read");
    wb_xfer(32'h3000_03FC, 1'b1, 4'h9, 32'hA5A5_0F0F, 0, 32'hFFFF_FFFF, "wb_write");
  endtask

  task automatic test_la();
    la_xfer(8'h22, 1'b1, 32'hCAFE_F00D, 1, 32'h1111_1111, "la_write");
    la_xfer(8'h23, 1'b0, 32'h0, 2, 32'h0BAD_F00D, "la_read");
  endtask

  task automatic test_arbitration();
    treq_t e_wb, e_la, obs, e;
    logic win_wb;
    int got;
    for (int r = 0; r < 4; r++) begin
      e_wb = '{1'b1, 4'h3, 8'(4 * r), 32'h1000_0000 + 32'(r)};
      e_la = '{1'b1, 4'hF, 8'(8'h80 + r), 32'h2000_0000 + 32'(r)};
      la_adr_i = e_la.adr; la_we_i = 1'b1; la_dat_i = e_la.dat; la_req_i = 1'b1;
      tick(); tick();
      wbs_adr_i = 32'h3000_0000 + 32'(16 * r); wbs_we_i = 1'b1; wbs_sel_i = 4'h3;
      wbs_dat_i = e_wb.dat; wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1;
      win_wb = mdl_last_la;
      mdl_last_la = ~win_wb;
      if (win_wb) begin exp_t.push_back(e_wb); exp_t.push_back(e_la); end
      else begin exp_t.push_back(e_la); exp_t.push_back(e_wb); end
      got = 0;
      for (int c = 0; c < 60; c++) begin
        if (got == 2 && !wbs_cyc_i && !la_req_i && !la_ack_o) break;
        t_ack_i = 1'b0;
        if (wbs_ack_o) begin wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; end
        if (la_ack_o) la_req_i = 1'b0;
        if (t_req_o && exp_t.size() > 0) begin
          obs = {t_we_o, t_sel_o, t_adr_o, t_dat_o};
          e = exp_t.pop_front();
          n_checks++;
          if (obs !== e) $display("FAIL arb_round%0d_grant%0d: got %h expected %h", r, got, obs, e);
          else n_pass++;
          t_ack_i = 1'b1;
          got++;
        end
        tick();
      end
      t_ack_i = 1'b0;
      n_checks++;
      if (got != 2) $display("FAIL arb_round%0d_done: %0d grants expected 2", r, got);
      else n_pass++;
      exp_t.delete();
      wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; la_req_i = 1'b0;
      repeat (2) tick();
    end
  endtask

  task automatic test_out_of_window();
    logic seen_req, seen_ack;
    seen_req = 1'b0; seen_ack = 1'b0;
    wbs_adr_i = 32'h2000_0000; wbs_we_i = 1'b0; wbs_sel_i = 4'hF;
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1;
    for (int c = 0; c < 50; c++) begin
      t_ack_i = (c == 5); t_dat_i = 32'h7777_7777;
      tick();
      if (t_req_o) seen_req = 1'b1;
      if (wbs_ack_o || la_ack_o) seen_ack = 1'b1;
    end
    t_ack_i = 1'b0; t_dat_i = 32'h0;
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
    n_checks++;
    if ({seen_req, seen_ack} !== 2'b00)
      $display("FAIL out_of_window: req %b ack %b expected 0 0", seen_req, seen_ack);
    else n_pass++;
    tick();
  endtask

  task automatic test_back_to_back();
    int nreq, nack;
    logic [31:0] er;
    nreq = 0; nack = 0;
    exp_rd.push_back(32'hB0B0_0000);
    exp_rd.push_back(32'hB0B0_0001);
    wbs_adr_i = 32'h3000_0020; wbs_we_i = 1'b0; wbs_sel_i = 4'hF;
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1;
    for (int c = 0; c < 40; c++) begin
      tick();
      t_ack_i = 1'b0;
      if (wbs_ack_o) begin
        er = exp_rd.pop_front();
        n_checks++;
        if (wbs_dat_o !== er) $display("FAIL b2b_data%0d: got %h expected %h", nack, wbs_dat_o, er);
        else n_pass++;
        nack++;
        if (nack == 2) begin wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; break; end
      end
      if (t_req_o && nreq < 2) begin
        t_ack_i = 1'b1; t_dat_i = 32'hB0B0_0000 + 32'(nreq);
        nreq++;
      end
    end
    t_ack_i = 1'b0;
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
    exp_rd.delete();
    n_checks++;
    if (nreq != 2 || nack != 2) $display("FAIL b2b_count: req %0d ack %0d expected 2 2", nreq, nack);
    else n_pass++;
    repeat (2) tick();
  endtask

  task automatic test_abort();
    logic seen_ack;
    seen_ack = 1'b0;
    wbs_adr_i = 32'h3000_0030; wbs_we_i = 1'b0; wbs_sel_i = 4'hF;
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1;
    tick();
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
    tick(); tick();
    t_ack_i = 1'b1; t_dat_i = 32'h5555_AAAA;
    tick();
    t_ack_i = 1'b0; t_dat_i = 32'h0;
    for (int c = 0; c < 6; c++) begin
      if (wbs_ack_o) seen_ack = 1'b1;
      tick();
    end
    n_checks++;
    if ({seen_ack, t_req_o} !== 2'b00)
      $display("FAIL abort: ack %b req %b expected 0 0", seen_ack, t_req_o);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    logic [111:0] obs;
    wbs_adr_i = 32'h3000_0044; wbs_we_i = 1'b0; wbs_sel_i = 4'hF;
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1;
    tick(); tick(); tick();
    wb_rst_i = 1'b1;
    #1;
    obs = {t_req_o, t_we_o, t_sel_o, t_adr_o, t_dat_o, wbs_ack_o, wbs_dat_o, la_ack_o, la_dat_o, irq_o};
    n_checks++;
    if (obs !== '0) $display("FAIL reset_mid_outputs: got %h expected 0", obs);
    else n_pass++;
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
    tick();
    wb_rst_i = 1'b0;
    mdl_last_la = 1'b1;
    exp_t.delete(); exp_rd.delete();
    tick();
    wb_xfer(32'h3000_0048, 1'b0, 4'hC, 32'h0, 2, 32'h600D_0001, "post_reset");
  endtask

  task automatic test_watchdog();
    int n_req, n_irq, n_wack;
    logic [31:0] ackdat;
    n_req = 0; n_irq = 0; n_wack = 0; ackdat = 32'h0;
    wbs_adr_i = 32'h3000_0050; wbs_we_i = 1'b0; wbs_sel_i = 4'hF;
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1;
`ifdef ARB_WATCHDOG_EN
    for (int c = 0; c < 40; c++) begin
      tick();
      if (t_req_o) n_req++;
      if (irq_o) n_irq++;
      if (wbs_ack_o) begin
        ackdat = wbs_dat_o; n_wack++;
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
      end
    end
    n_checks++;
    if (n_req != 16) $display("FAIL wdog_req_cycles: %0d expected 16", n_req);
    else n_pass++;
    n_checks++;
    if (n_wack != 1 || ackdat !== 32'hDEAD_BEEF)
      $display("FAIL wdog_ack: acks %0d dat %h expected 1 deadbeef", n_wack, ackdat);
    else n_pass++;
    n_checks++;
    if (n_irq != 1) $display("FAIL wdog_irq: %0d pulses expected 1", n_irq);
    else n_pass++;
`else
    for (int c = 0; c < 40; c++) begin
      tick();
      if (t_req_o) n_req++;
      if (irq_o) n_irq++;
    end
    n_checks++;
    if (n_req != 40 || n_irq != 0)
      $display("FAIL no_wdog_wait: req %0d irq %0d expected 40 0", n_req, n_irq);
    else n_pass++;
    t_ack_i = 1'b1; t_dat_i = 32'h0123_4567;
    tick();
    t_ack_i = 1'b0; t_dat_i = 32'h0;
    ackdat = wbs_dat_o;
    n_wack = int'(wbs_ack_o);
    n_checks++;
    if (n_wack != 1 || ackdat !== 32'h0123_4567)
      $display("FAIL no_wdog_ack: ack %0d dat %h expected 1 01234567", n_wack, ackdat);
    else n_pass++;
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
`endif
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
    repeat (3) tick();
  endtask

  initial begin
    wb_rst_i = 1'b1;
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0; wbs_sel_i = 4'h0;
    wbs_adr_i = 32'h0; wbs_dat_i = 32'h0;
    la_req_i = 1'b0; la_we_i = 1'b0; la_adr_i = 8'h0; la_dat_i = 32'h0;
    t_ack_i = 1'b0; t_dat_i = 32'h0;
    mdl_last_la = 1'b1;
    test_reset();
    test_wb_read();
    test_la();
    test_arbitration();
    test_out_of_window();
    test_back_to_back();
    test_abort();
    test_reset_mid();
    test_watchdog();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, passed %0d of %0d", n_pass, n_checks);
    $fatal(1);
  end

endmodule
